// File: rtl/cdb_arbiter_pkg.sv
// Shared CDB types: broadcast payload, source count and source index type.
package tomasula_types;

  localparam int unsigned NUM_CDB_SRC = 8;
  localparam int unsigned CDB_SRC_W   = $clog2(NUM_CDB_SRC);
  localparam int unsigned CDB_TAG_W   = 3;
  localparam int unsigned CDB_DATA_W  = 32;

  typedef logic [CDB_SRC_W-1:0] cdb_src_idx_t;

  typedef struct packed {
    logic [CDB_TAG_W-1:0]  tag;
    logic [CDB_DATA_W-1:0] data;
  } cdb_entry_t;

endpackage

// File: rtl/cdb_arbiter_rr.sv
// Combinational round-robin grant: first requester at or after ptr_i wins.
module rr_arbiter #(
  parameter  int unsigned NUM_SRC = 8,
  localparam int unsigned IDX_W   = $clog2(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [NUM_SRC-1:0] grant_o,
  output logic [IDX_W-1:0]   grant_idx_o,
  output logic               any_grant_o
);

  logic [IDX_W-1:0] idx;
  logic             found;

  // Scan requesters starting at the pointer; the index wraps in IDX_W bits.
  always_comb begin
    grant_o     = '0;
    grant_idx_o = '0;
    any_grant_o = 1'b0;
    idx         = '0;
    found       = 1'b0;
    for (int unsigned k = 0; k < NUM_SRC; k++) begin
      idx = IDX_W'(ptr_i + IDX_W'(k));
      if (!found && req_i[idx]) begin
        found        = 1'b1;
        grant_o[idx] = 1'b1;
        grant_idx_o  = idx;
      end
    end
    any_grant_o = found;
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: per-source one-entry hold registers, round-robin
// selection, registered broadcast of one result per cycle.
module cdb_arbiter
  import tomasula_types::*;
#(
  parameter int unsigned NUM_SRC = NUM_CDB_SRC,
  parameter int unsigned TAG_W   = CDB_TAG_W,
  parameter int unsigned DATA_W  = CDB_DATA_W
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             flush,
  input  logic [NUM_SRC-1:0]               src_valid,
  input  logic [NUM_SRC-1:0][TAG_W-1:0]    src_tag,
  input  logic [NUM_SRC-1:0][DATA_W-1:0]   src_data,
  output logic [NUM_SRC-1:0]               src_ready,
  output logic                             cdb_valid,
  output logic [TAG_W-1:0]                 cdb_tag,
  output logic [DATA_W-1:0]                cdb_data,
  output logic [$clog2(NUM_SRC)-1:0]       cdb_src
);

  localparam int unsigned IDX_W = $clog2(NUM_SRC);

  logic [NUM_SRC-1:0]              hold_valid_q, hold_valid_d;
  cdb_entry_t [NUM_SRC-1:0]        hold_q, hold_d;
  logic [IDX_W-1:0]                ptr_q, ptr_d;
  logic                            cdb_valid_q, cdb_valid_d;
  cdb_entry_t                      cdb_q, cdb_d;
  logic [IDX_W-1:0]                cdb_src_q, cdb_src_d;

  logic [NUM_SRC-1:0]              req;
  logic [NUM_SRC-1:0]              grant;
  logic [IDX_W-1:0]                grant_idx;
  logic                            any_grant;
  logic [NUM_SRC-1:0]              accept;

  // Flush suppresses all requests so nothing is granted on that edge.
  assign req = flush ? '0 : hold_valid_q;

  rr_arbiter #(.NUM_SRC(NUM_SRC)) u_rr (
    .req_i       (req),
    .ptr_i       (ptr_q),
    .grant_o     (grant),
    .grant_idx_o (grant_idx),
    .any_grant_o (any_grant)
  );

  // A slot accepts when empty or being drained this cycle; independent of src_valid.
  assign src_ready = flush ? '0 : (~hold_valid_q | grant);
  assign accept    = src_valid & src_ready;

  // Next-state: hold slots (refill beats clear), bus payload and pointer.
  always_comb begin
    hold_valid_d = hold_valid_q;
    hold_d       = hold_q;
    ptr_d        = ptr_q;
    cdb_valid_d  = any_grant;
    cdb_d        = cdb_q;
    cdb_src_d    = cdb_src_q;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (flush) begin
        hold_valid_d[i] = 1'b0;
      end else begin
        if (grant[i]) begin
          hold_valid_d[i] = 1'b0;
        end
        if (accept[i]) begin
          hold_valid_d[i] = 1'b1;
          hold_d[i].tag   = CDB_TAG_W'(src_tag[i]);
          hold_d[i].data  = CDB_DATA_W'(src_data[i]);
        end
      end
    end
    if (any_grant) begin
      cdb_d     = hold_q[grant_idx];
      cdb_src_d = grant_idx;
      ptr_d     = IDX_W'(grant_idx + IDX_W'(1));
    end
  end

  // State registers; reset drops every pending result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_valid_q <= '0;
      hold_q       <= '0;
      ptr_q        <= '0;
      cdb_valid_q  <= 1'b0;
      cdb_q        <= '0;
      cdb_src_q    <= '0;
    end else begin
      hold_valid_q <= hold_valid_d;
      hold_q       <= hold_d;
      ptr_q        <= ptr_d;
      cdb_valid_q  <= cdb_valid_d;
      cdb_q        <= cdb_d;
      cdb_src_q    <= cdb_src_d;
    end
  end

  assign cdb_valid = cdb_valid_q;
  assign cdb_tag   = TAG_W'(cdb_q.tag);
  assign cdb_data  = DATA_W'(cdb_q.data);
  assign cdb_src   = cdb_src_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboard bench for cdb_arbiter with a slot-level reference model.
module tb_cdb_arbiter;

  localparam int N = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             flush = 1'b0;
  logic [N-1:0]     src_valid = '0;
  logic [N-1:0][2:0]  src_tag = '0;
  logic [N-1:0][31:0] src_data = '0;
  logic [N-1:0]     src_ready;
  logic             cdb_valid;
  logic [2:0]       cdb_tag;
  logic [31:0]      cdb_data;
  logic [2:0]       cdb_src;

  cdb_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .src_valid (src_valid),
    .src_tag   (src_tag),
    .src_data  (src_data),
    .src_ready (src_ready),
    .cdb_valid (cdb_valid),
    .cdb_tag   (cdb_tag),
    .cdb_data  (cdb_data),
    .cdb_src   (cdb_src)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  tag;
    logic [31:0] data;
    int          src;
  } exp_t;

  exp_t expq[$];
  int   bc_log[$];
  int   checks = 0;
  int   failures = 0;

  // Reference model: one slot per source, rotating priority pointer.
  bit          mv[N];
  logic [2:0]  mt[N];
  logic [31:0] md[N];
  int          mage[N];
  int          mptr = 0;
  int          cyc = 0;
  int          seq = 0;
  logic [2:0]  tag_in[N];
  logic [31:0] data_in[N];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < N; i++) mv[i] = 1'b0;
  endtask

  task automatic rand_payload();
    for (int i = 0; i < N; i++) begin
      tag_in[i]  = 3'($urandom);
      data_in[i] = {8'(i), 24'(seq)};
    end
    seq++;
  endtask

  // One cycle: drive at negedge, check ready, advance model at posedge.
  task automatic step(input logic [N-1:0] v, input logic fl);
    int w;
    logic [N-1:0] rdy;
    src_valid = v;
    flush     = fl;
    for (int i = 0; i < N; i++) begin
      src_tag[i]  = tag_in[i];
      src_data[i] = data_in[i];
    end
    w = -1;
    if (!fl) begin
      for (int k = 0; k < N; k++) begin
        if (w < 0 && mv[(mptr + k) % N]) w = (mptr + k) % N;
      end
    end
    for (int i = 0; i < N; i++) rdy[i] = !fl && (!mv[i] || w == i);
    #1;
    chk("src_ready", 64'(src_ready), 64'(rdy));
    @(posedge clk);
    cyc++;
    if (fl) begin
      model_clear();
    end else begin
      if (w >= 0) begin
        expq.push_back('{mt[w], md[w], w});
        checks++;
        if (cyc - mage[w] > N) begin
          failures++;
          $display("FAIL wait_bound src=%0d actual=%0d required<=%0d", w, cyc - mage[w], N);
        end
        mv[w] = 1'b0;
        mptr  = (w + 1) % N;
      end
      for (int i = 0; i < N; i++) begin
        if (v[i] && rdy[i]) begin
          mv[i]   = 1'b1;
          mt[i]   = tag_in[i];
          md[i]   = data_in[i];
          mage[i] = cyc;
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step('0, 1'b0);
  endtask

  // Asynchronous reset applied between edges, released on a later negedge.
  task automatic do_reset();
    src_valid = '0;
    flush     = 1'b0;
    rst       = 1'b1;
    #1;
    chk("rst_cdb_valid", 64'(cdb_valid), 64'(0));
    model_clear();
    mptr = 0;
    expq.delete();
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_src_ready", 64'(src_ready), 64'hFF);
    @(negedge clk);
  endtask

  // Monitor: every broadcast must match the head of the expected queue.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (!rst) begin
      if (cdb_valid) begin
        checks++;
        if (expq.size() == 0) begin
          failures++;
          $display("FAIL cdb_unexpected actual src=%0d tag=%0d data=%h required none",
                   cdb_src, cdb_tag, cdb_data);
        end else begin
          e = expq.pop_front();
          if (cdb_tag !== e.tag || cdb_data !== e.data || int'(cdb_src) != e.src) begin
            failures++;
            $display("FAIL cdb_payload actual src=%0d tag=%0d data=%h required src=%0d tag=%0d data=%h",
                     cdb_src, cdb_tag, cdb_data, e.src, e.tag, e.data);
          end
        end
        bc_log.push_back(int'(cdb_src));
      end else if (expq.size() != 0) begin
        checks++;
        failures++;
        e = expq.pop_front();
        $display("FAIL cdb_missing actual valid=0 required src=%0d tag=%0d data=%h",
                 e.src, e.tag, e.data);
      end
    end
  end

  initial begin
    int same;
    for (int i = 0; i < N; i++) begin
      tag_in[i] = '0; data_in[i] = '0; mage[i] = 0;
    end
    model_clear();
    #2;
    chk("rst_cdb_tag",  64'(cdb_tag), 64'(0));
    chk("rst_cdb_data", 64'(cdb_data), 64'(0));
    chk("rst_cdb_src",  64'(cdb_src), 64'(0));
    @(negedge clk);
    do_reset();

    // Single source: src 2, tag 5, DEADBEEF.
    tag_in[2] = 3'd5; data_in[2] = 32'hDEADBEEF;
    step(8'h04, 1'b0);
    step(8'h00, 1'b0);
    chk("single_valid", 64'(cdb_valid), 64'(1));
    chk("single_tag",   64'(cdb_tag), 64'(5));
    chk("single_data",  64'(cdb_data), 64'hDEADBEEF);
    chk("single_src",   64'(cdb_src), 64'(2));
    idle(2);

    // Reset mid-run with three entries pending and a broadcast in flight.
    rand_payload();
    step(8'h0B, 1'b0);
    rand_payload();
    step(8'h01, 1'b0);
    do_reset();
    bc_log.delete();
    idle(4);
    chk("rst_no_broadcast", 64'(bc_log.size()), 64'(0));

    // Round-robin from ptr=0: sources 0,3,7.
    rand_payload();
    step(8'h89, 1'b0);
    idle(3);
    chk("rr1_count", 64'(bc_log.size()), 64'(3));
    if (bc_log.size() == 3)
      chk("rr1_order", {52'(0), 4'(bc_log[0]), 4'(bc_log[1]), 4'(bc_log[2])}, 64'h037);
    // Move ptr to 4 via a lone src 3 grant, then present 3 and 7.
    rand_payload();
    step(8'h08, 1'b0);
    idle(2);
    bc_log.delete();
    rand_payload();
    step(8'h88, 1'b0);
    idle(3);
    chk("rr2_count", 64'(bc_log.size()), 64'(2));
    if (bc_log.size() == 2)
      chk("rr2_order", {56'(0), 4'(bc_log[0]), 4'(bc_log[1])}, 64'h73);

    // Back-pressure: sources 0 and 1 always valid.
    bc_log.delete();
    for (int c = 0; c < 10; c++) begin
      rand_payload();
      step(8'h03, 1'b0);
    end
    idle(3);
    same = 0;
    for (int k = 0; k + 1 < bc_log.size(); k++)
      if (bc_log[k] == bc_log[k+1]) same++;
    chk("bp_alternate", 64'(same), 64'(0));
    chk("bp_count_ok", 64'(bc_log.size() >= 10), 64'(1));

    // Flush with entries pending and a broadcast in flight.
    rand_payload();
    step(8'h0F, 1'b0);
    rand_payload();
    step(8'hF0, 1'b0);
    step(8'h00, 1'b1);
    chk("flush_cdb_valid", 64'(cdb_valid), 64'(0));
    bc_log.delete();
    tag_in[5] = 3'd6; data_in[5] = 32'h0000_5555;
    step(8'h20, 1'b0);
    idle(4);
    chk("flush_count", 64'(bc_log.size()), 64'(1));
    if (bc_log.size() == 1) chk("flush_src5", 64'(bc_log[0]), 64'(5));

    // Saturation random.
    for (int c = 0; c < 10000; c++) begin
      rand_payload();
      step(8'($urandom), 1'b0);
    end
    // Random with occasional flush.
    for (int c = 0; c < 1000; c++) begin
      rand_payload();
      step(8'($urandom), ($urandom_range(0, 49) == 0));
    end
    idle(12);
    chk("drain_empty", 64'(expq.size()), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Collects completed results from up to eight functional units and serialises them onto the single common data bus, one broadcast per cycle. Each source owns a one-entry holding register, so a unit hands off its result and frees itself even when the bus is busy. A round-robin arbiter picks among pending entries, and the winner is registered onto the bus outputs. Downstream, the per-entry CDB latches and the ROB/reservation-station tag compare consume these outputs.

## Interface
- NUM_SRC, 8, number of producing units; must be a power of two, 2..8
- TAG_W, 3, ROB tag width
- DATA_W, 32, result width
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset, asynchronous, active-high
- flush  in  1  pipeline flush; discards every pending and outgoing result
- src_valid  in  NUM_SRC  source i presents a result
- src_tag  in  NUM_SRC x TAG_W  ROB tag per source
- src_data  in  NUM_SRC x DATA_W  result value per source
- src_ready  out  NUM_SRC  source i's result is accepted at this edge
- cdb_valid  out  1  broadcast valid this cycle
- cdb_tag  out  TAG_W  broadcast tag
- cdb_data  out  DATA_W  broadcast value
- cdb_src  out  $clog2(NUM_SRC)  index of the winning source

## Operation
- Per-source holding register: hold_valid[i], hold_tag[i], hold_data[i].
- Accept rule:
  - src_ready[i] = !flush && (!hold_valid[i] || grant[i]).
  - A transfer occurs on src_valid[i] && src_ready[i]. The holding register loads at that edge.
- Arbitration is combinational over hold_valid.
  - Priority starts at ptr, then ptr+1, and so on, modulo NUM_SRC.
  - At most one grant[i] per cycle.
  - No grant while flush is high.
- On a grant:
  - The cdb output registers load the winner's tag, data and index.
  - hold_valid[winner] clears unless a new transfer from the same source refills it at the same edge. The refill wins: hold_valid stays 1 with the new contents.
- Pointer update: ptr <= winner+1 (wraps from NUM_SRC-1 to 0). With no grant, ptr holds.
- Broadcast validity: cdb_valid <= any grant. With no grant, cdb_valid <= 0 and cdb_tag/cdb_data/cdb_src hold their last values (don't care).
- Flush: at the edge where flush=1, all hold_valid <= 0 and cdb_valid <= 0, and no transfer is accepted. ptr is unchanged.
- Reset (async, immediate):
  - all hold_valid = 0, ptr = 0
  - cdb_valid = 0, cdb_tag = 0, cdb_data = 0, cdb_src = 0
  - src_ready goes to all-ones combinationally once flush=0
  - Reset mid-operation drops every pending result with no broadcast.
- Arithmetic: the pointer is $clog2(NUM_SRC) bits and wraps naturally, which is why NUM_SRC must be a power of two.

## Timing
- Latency: a result accepted at edge E is visible on the cdb at the earliest after edge E+1, i.e. 2 cycles from src_valid to cdb_valid.
- Throughput: one broadcast per cycle sustained whenever any hold entry is valid.
- Each source can sustain one result per cycle only when it wins every cycle. Otherwise src_ready[i] drops while its entry waits.
- Starvation bound: a valid entry is granted within NUM_SRC cycles of becoming valid, in the absence of flush.
- src_ready depends combinationally on hold_valid, grant and flush, but not on src_valid, so there is no combinational loop with producers.
- cdb_* outputs come directly from flops.
- Simultaneous events:
  - flush beats accept and grant.
  - A same-source refill beats the clear.
  - A grant and an accept on different sources in the same cycle are independent.

## Structure
- Shared package tomasula_types gains:
  - cdb_entry_t packed struct {tag, data}
  - constant NUM_CDB_SRC = 8
  - the CDB source index typedef
- Hold registers and cdb outputs use cdb_entry_t.
- One sub-module, rr_arbiter: a combinational round-robin grant with inputs req[NUM_SRC] and ptr, and outputs grant one-hot, grant_idx and any_grant. Instantiate it once; the pointer flop stays in cdb_arbiter.

## Test plan
- Reset/idle: assert rst mid-run with 3 hold entries valid → cdb_valid=0 immediately; no broadcast after release; src_ready=8'hFF.
- Single source: src 2 presents tag 5, data 32'hDEADBEEF in cycle 0 → cdb_valid=1, tag 5, data DEADBEEF, cdb_src 2 after edge 2; src_ready[2] stays high throughout.
- Round-robin:
  - Setup: sources 0, 3, 7 present in the same cycle with ptr=0.
  - Expected: broadcasts in order 0, 3, 7 on consecutive cycles, then ptr=0.
  - Then re-present 3 and 7 with ptr=4 → order 7, 3.
- Back-pressure/refill: src 1 asserts valid every cycle while src 0 is also always valid → broadcasts alternate 0,1,0,1; src_ready[1] toggles; no result is lost or duplicated (scoreboard by tag).
- Flush: 4 entries pending plus a cdb_valid in flight; assert flush one cycle → next cycle cdb_valid=0; none of the 4 tags ever broadcast; a new src 5 result accepted after flush appears 2 cycles later.
- Saturation random: all 8 sources random valid for 10k cycles → every accepted tag broadcast exactly once, and no wait exceeds 8 cycles.
